// File: rtl/dtcm.sv
// Data tightly-coupled memory: one load/store per cycle, 1-cycle response, a 1-entry
// write buffer with load forwarding, and a zero-fill sweep of the array after reset.
module dtcm #(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v_m,
  output logic        req_ready_m,
  input  logic        req_we_m,
  input  logic [1:0]  req_size_m,
  input  logic        req_unsigned_m,
  input  logic [31:0] req_addr_m,
  input  logic [31:0] req_wdata_m,
  output logic        rsp_v_w,
  output logic [31:0] rsp_data_w,
  output logic        rsp_err_w
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [31:0] WinBytes = 32'(DEPTH * 4);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   cnt_q;
  logic [31:0]       mem [DEPTH];

  // Write buffer
  logic              wb_v_q;
  logic [IdxW-1:0]   wb_idx_q;
  logic [31:0]       wb_data_q;
  logic [3:0]        wb_be_q;

  // Response pipeline
  logic              rsp_v_q;
  logic              rsp_err_q;
  logic              ld_q;
  logic [1:0]        ld_size_q;
  logic              ld_uns_q;
  logic [1:0]        ld_lane_q;
  logic [3:0]        fwd_be_q;
  logic [31:0]       fwd_data_q;
  logic [31:0]       rd_q;

  logic              acc;
  logic [31:0]       offset;
  logic              in_win;
  logic              misal;
  logic              fault;
  logic [IdxW-1:0]   acc_idx;
  logic [1:0]        lane;
  logic              st_acc;
  logic              ld_acc;
  logic              fwd_hit;
  logic [31:0]       st_data;
  logic [3:0]        st_be;

  assign req_ready_m = (state_q == StRun);
  assign acc         = req_v_m & req_ready_m;
  assign offset      = req_addr_m - BASE;
  assign in_win      = (req_addr_m >= BASE) && (offset < WinBytes);
  assign acc_idx     = offset[IdxW+1:2];
  assign lane        = req_addr_m[1:0];

  always_comb begin
    misal   = 1'b0;
    st_data = req_wdata_m;
    st_be   = 4'b1111;
    case (req_size_m)
      2'd0: begin
        st_data = {4{req_wdata_m[7:0]}};
        st_be   = 4'b0001 << lane;
      end
      2'd1: begin
        misal   = req_addr_m[0];
        st_data = {2{req_wdata_m[15:0]}};
        st_be   = 4'b0011 << lane;
      end
      2'd2: misal = (req_addr_m[1:0] != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  assign fault   = !in_win || misal;
  assign st_acc  = acc && req_we_m && !fault;
  assign ld_acc  = acc && !req_we_m && !fault;
  assign fwd_hit = wb_v_q && (wb_idx_q == acc_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      wb_v_q     <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_be_q    <= '0;
      rsp_v_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      ld_q       <= 1'b0;
      ld_size_q  <= '0;
      ld_uns_q   <= 1'b0;
      ld_lane_q  <= '0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      rsp_v_q   <= acc;
      rsp_err_q <= acc && fault;
      ld_q      <= ld_acc;
      if (ld_acc) begin
        ld_size_q  <= req_size_m;
        ld_uns_q   <= req_unsigned_m;
        ld_lane_q  <= lane;
        fwd_be_q   <= fwd_hit ? wb_be_q : 4'b0000;
        fwd_data_q <= wb_data_q;
      end
      // A valid entry always drains next cycle, so a new capture simply replaces it.
      wb_v_q <= st_acc;
      if (st_acc) begin
        wb_idx_q  <= acc_idx;
        wb_data_q <= st_data;
        wb_be_q   <= st_be;
      end
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IdxW'(DEPTH - 1)) state_q <= StRun;
        end
        StRun: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (wb_v_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be_q[b]) mem[wb_idx_q][8*b +: 8] <= wb_data_q[8*b +: 8];
      end
    end
    if (ld_acc) rd_q <= mem[acc_idx];
  end

  logic [31:0] be_mask;
  logic [31:0] merged;
  logic [31:0] shifted;

  assign be_mask = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};
  // Bytes still held in the buffer at accept time override the (stale) array read.
  assign merged  = (fwd_data_q & be_mask) | (rd_q & ~be_mask);
  assign shifted = merged >> {ld_lane_q, 3'b000};

  always_comb begin
    rsp_data_w = '0;
    if (ld_q) begin
      case (ld_size_q)
        2'd0:    rsp_data_w = {{24{shifted[7] & ~ld_uns_q}}, shifted[7:0]};
        2'd1:    rsp_data_w = {{16{shifted[15] & ~ld_uns_q}}, shifted[15:0]};
        default: rsp_data_w = merged;
      endcase
    end
  end

  assign rsp_v_w   = rsp_v_q;
  assign rsp_err_w = rsp_err_q;

endmodule

// File: tb/tb_dtcm.sv
// Randomised scoreboard bench for dtcm against a byte-array reference model.
module tb_dtcm;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk;
  logic        reset;
  logic        req_v_m;
  logic        req_ready_m;
  logic        req_we_m;
  logic [1:0]  req_size_m;
  logic        req_unsigned_m;
  logic [31:0] req_addr_m;
  logic [31:0] req_wdata_m;
  logic        rsp_v_w;
  logic [31:0] rsp_data_w;
  logic        rsp_err_w;

  dtcm #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .req_v_m(req_v_m), .req_ready_m(req_ready_m),
    .req_we_m(req_we_m), .req_size_m(req_size_m), .req_unsigned_m(req_unsigned_m),
    .req_addr_m(req_addr_m), .req_wdata_m(req_wdata_m), .rsp_v_w(rsp_v_w),
    .rsp_data_w(rsp_data_w), .rsp_err_w(rsp_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  byte unsigned ref_mem [DEPTH*4];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference: flat byte memory, requests applied strictly in acceptance order.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] d, output logic err);
    logic [31:0] off;
    int nb;
    off = addr - BASE;
    err = (addr < BASE) || (off >= DEPTH*4) || (size == 2'd3) ||
          (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    d = '0;
    if (err) return;
    nb = 1 << size;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[off + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) d |= 32'(ref_mem[off + i]) << (8*i);
      if (!uns && nb < 4 && d[8*nb-1]) d |= 32'hFFFF_FFFF << (8*nb);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (rsp_v_w) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_v_w=1 expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_data"}, rsp_data_w, mon_e.data);
          check({mon_e.name, "_err"}, 32'(rsp_err_w), 32'(mon_e.err));
        end
      end else begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_rsp %s: got rsp_v_w=0 expected 1", mon_e.name);
        end
        check("idle_data", rsp_data_w, 32'h0);
        check("idle_err", 32'(rsp_err_w), 32'h0);
      end
    end
  end

  task automatic idle(input int n);
    req_v_m = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input string nm, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    exp_t e;
    n = 0;
    req_v_m = 1'b1;
    req_we_m = we;
    req_size_m = size;
    req_unsigned_m = uns;
    req_addr_m = addr;
    req_wdata_m = wdata;
    while (!req_ready_m && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready_m) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout %s: got ready=0 expected 1", nm);
      return;
    end
    @(posedge clk);
    model(we, size, uns, addr, wdata, e.data, e.err);
    e.name = nm;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    #1;
    while (!req_ready_m && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("init_cycles", 32'(cnt), 32'(DEPTH));
  endtask

  task automatic check_rst_outputs(input string nm);
    check({nm, "_v"}, 32'(rsp_v_w), 32'h0);
    check({nm, "_data"}, rsp_data_w, 32'h0);
    check({nm, "_err"}, 32'(rsp_err_w), 32'h0);
    check({nm, "_ready"}, 32'(req_ready_m), 32'h0);
  endtask

  initial begin
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          n;

    reset = 1'b0;
    req_v_m = 1'b0;
    req_we_m = 1'b0;
    req_size_m = 2'd0;
    req_unsigned_m = 1'b0;
    req_addr_m = '0;
    req_wdata_m = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    #1;
    check_rst_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_init();

    issue("ld_init_3c", 1'b0, 2'd2, 1'b0, BASE + 32'h3C, 32'h0);
    idle(1);

    issue("st_beef", 1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hDEAD_BEEF);
    issue("ld_fwd_8", 1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'h0);
    issue("st_cafe", 1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hCAFE_F00D);
    idle(3);
    issue("ld_arr_8", 1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'h0);

    issue("st_b80", 1'b1, 2'd0, 1'b0, BASE + 32'h5, 32'h0000_0080);
    issue("st_h1234", 1'b1, 2'd1, 1'b0, BASE + 32'h6, 32'h0000_1234);
    issue("ld_w4", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    issue("ld_bs5", 1'b0, 2'd0, 1'b0, BASE + 32'h5, 32'h0);
    issue("ld_bu5", 1'b0, 2'd0, 1'b1, BASE + 32'h5, 32'h0);
    issue("ld_h6", 1'b0, 2'd1, 1'b0, BASE + 32'h6, 32'h0);
    idle(2);

    issue("flt_st_mis", 1'b1, 2'd2, 1'b0, BASE + 32'h2, 32'hFFFF_FFFF);
    issue("ld_w4_a", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    issue("flt_ld_h1", 1'b0, 2'd1, 1'b0, BASE + 32'h1, 32'h0);
    issue("ld_w4_b", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    issue("flt_below", 1'b0, 2'd2, 1'b0, BASE - 32'h4, 32'h0);
    issue("ld_w4_c", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    issue("flt_above", 1'b0, 2'd2, 1'b0, BASE + 32'(DEPTH*4), 32'h0);
    issue("ld_w4_d", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    issue("flt_sz3", 1'b1, 2'd3, 1'b0, BASE + 32'h4, 32'h1111_1111);
    issue("ld_w4_e", 1'b0, 2'd2, 1'b0, BASE + 32'h4, 32'h0);
    idle(2);

    for (int i = 0; i < 8; i++) issue("stream_st", 1'b1, 2'd2, 1'b0, BASE + 32'(4*i), 32'(i));
    for (int i = 0; i < 8; i++) issue("stream_ld", 1'b0, 2'd2, 1'b0, BASE + 32'(4*i), 32'h0);
    idle(2);

    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
      if (sz != 2'd3 && $urandom_range(0, 7) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      n = $urandom_range(0, 29);
      if (n == 0) addr = BASE - 32'($urandom_range(1, 64));
      else if (n == 1) addr = BASE + 32'(DEPTH*4) + 32'($urandom_range(0, 64));
      issue("rand", we, sz, 1'($urandom_range(0, 1)), addr, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Reset during the cycle the store sits in the write buffer.
    issue("st_a5", 1'b1, 2'd2, 1'b0, BASE, 32'hA5A5_A5A5);
    #2;
    reset = 1'b0;
    #1;
    check_rst_outputs("midrst");
    exp_q.delete();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_init();
    issue("ld_after_rst", 1'b0, 2'd2, 1'b0, BASE, 32'h0);
    idle(3);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtcm.md
Name: dtcm

Overview:
- Data tightly-coupled memory. It is the responder for CPU load/store accesses, on the data side alongside the instruction fetch path.
- Accepts one request per cycle over a valid/ready handshake and returns load data one cycle after acceptance.
- Holds stores in a 1-entry write buffer and forwards from it. After reset it zero-fills the array with an internal sweep.

Parameters:
- DEPTH, 4096, number of 32-bit words (power of 2, ≥4).
- BASE, 32'h0001_0000, byte address of word 0; window size is DEPTH*4 bytes.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_v_m  in  1  request valid.
- req_ready_m  out  1  responder can accept; request accepted when req_v_m & req_ready_m.
- req_we_m  in  1  1 = store, 0 = load.
- req_size_m  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_m  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr_m  in  32  byte address.
- req_wdata_m  in  32  store data, right-aligned (bits [7:0] hold the byte for a byte store).
- rsp_v_w  out  1  response valid, one cycle after every accepted request (loads and stores).
- rsp_data_w  out  32  load result; 0 for stores and errors.
- rsp_err_w  out  1  access fault (misaligned, out of window, or size 3).

Behaviour:
- Reset (reset==0, async):
  - rsp_v_w=0, rsp_data_w=0, rsp_err_w=0, req_ready_m=0.
  - Write buffer invalid. State=INIT, init counter=0.
- States:
  - INIT: write 0 to word[cnt], cnt++. After the write at cnt==DEPTH-1, go to RUN. Takes exactly DEPTH cycles; req_ready_m=0 throughout.
  - RUN: req_ready_m=1 every cycle, no backpressure.
  - Reset asserted in any state returns to INIT and restarts the sweep from 0. Any pending buffered store is dropped.
- Fault checks (on accepted request):
  - fault = addr<BASE or addr≥BASE+DEPTH*4, or size==3, or (size==1 & addr[0]), or (size==2 & addr[1:0]!=0).
  - A faulting access writes nothing and updates no buffer. Next cycle: rsp_v_w=1, rsp_err_w=1, rsp_data_w=0.
- Word index = (addr-BASE)>>2; byte lane = addr[1:0].
- Store accept:
  - Data is replicated into lanes: byte → {4{b}}; half → {2{h}}.
  - Byte enables: byte 1<<lane; half 4'b0011<<lane; word 4'b1111.
  - Captured into the write buffer (index, data, be, valid=1). The array is not written this cycle.
  - Response next cycle: rsp_v_w=1, err=0, data=0.
- Buffer drain:
  - A valid buffer is written to the array (byte-enabled) in the cycle after capture, then marked invalid.
  - If a new store is accepted in that same cycle, the old entry drains and the new one is captured in the same cycle. No stall, no loss.
- Load accept:
  - Array read is synchronous (registered read, 1-cycle latency).
  - If the buffer is valid with a matching index at accept, enabled bytes come from the buffer and the rest from the array (forwarding).
  - Next cycle: select the lane, then zero- or sign-extend per size and req_unsigned_m. rsp_v_w=1, err=0.
- Back-to-back accepts produce back-to-back responses, in order, with no bubbles.
- No request (or during INIT): rsp_v_w=0, and rsp_data_w/rsp_err_w return to 0.
- Requests presented during INIT are ignored (not accepted). The requester must hold them.

Test Plan:
- Init sweep (DEPTH=16): release reset → req_ready_m=0 for exactly 16 cycles, then 1. Load word at BASE+0x3C → rsp_data_w=0, err=0, one cycle after accept.
- Store then load: store word 0xDEADBEEF @BASE+8 (cycle n), load word @BASE+8 (cycle n+1) → response at n+2 = 0xDEADBEEF via forwarding. Repeat with 3 idle cycles in between → same value from the array.
- Sub-word: store byte 0x80 @BASE+5, store half 0x1234 @BASE+6.
  - Load word @BASE+4 → 0x12348000.
  - Load byte signed @BASE+5 → 0xFFFFFF80.
  - Load byte unsigned @BASE+5 → 0x00000080.
  - Load half @BASE+6 → 0x00001234.
- Faults (each → rsp_v_w=1, err=1, data=0; a following load of @BASE+4 is unchanged):
  - Store word @BASE+2.
  - Load half @BASE+1.
  - Load @BASE-4.
  - Load @BASE+DEPTH*4.
  - size=3.
- Streaming: 8 consecutive accepted stores to BASE+0..0x1C (data i), then 8 consecutive loads → 8 back-to-back responses returning 0..7 in order, no gaps.
- Reset mid-run: store 0xA5A5A5A5 @BASE+0, assert reset in the capture cycle → outputs 0 immediately (async). After the re-init sweep, load @BASE+0 returns 0.
